// File: rtl/mem_access_pkg.sv
// mem_access_pkg
//   Shared types and helpers for the memory access unit.
//   - ls_op_t : load/store/LUI operation codes presented on mem_access_unit.op
//   - state_t : sequencing states of mem_access_unit (also exported on dbg_state)
//   - lane_byte / lane_half : pick a byte / halfword out of a 32-bit bus word
//   - merge_lwl / merge_lwr : unaligned-word merge with the old register value
//   Byte lane k of a bus word is bits 8k+7:8k.
package mem_access_pkg;

    typedef enum logic [3:0] {
        NOP = 4'd0,
        LB  = 4'd1,
        LBU = 4'd2,
        LH  = 4'd3,
        LHU = 4'd4,
        LW  = 4'd5,
        LWL = 4'd6,
        LWR = 4'd7,
        LUI = 4'd8,
        SB  = 4'd9,
        SH  = 4'd10,
        SW  = 4'd11
    } ls_op_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    function automatic logic is_load(input ls_op_t op);
        return (op inside {LB, LBU, LH, LHU, LW, LWL, LWR});
    endfunction

    function automatic logic is_store(input ls_op_t op);
        return (op inside {SB, SH, SW});
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] b);
        logic [31:0] s;
        s = w >> {b, 3'b000};
        return s[7:0];
    endfunction

    function automatic logic [15:0] lane_half(input logic [31:0] w, input logic [1:0] b);
        logic [31:0] s;
        s = w >> {b, 3'b000};
        return s[15:0];
    endfunction

    // Memory word moves up by 8*(3-b); the register keeps its low 8*(3-b) bits.
    function automatic logic [31:0] merge_lwl(input logic [31:0] w, input logic [31:0] rt,
                                              input logic [1:0] b);
        logic [4:0]  sh;
        logic [31:0] keep;
        sh   = {~b, 3'b000};
        keep = (32'h1 << sh) - 32'h1;
        return (w << sh) | (rt & keep);
    endfunction

    // Memory word moves down by 8*b; the register keeps its high 8*b bits.
    function automatic logic [31:0] merge_lwr(input logic [31:0] w, input logic [31:0] rt,
                                              input logic [1:0] b);
        logic [4:0]  sh;
        logic [31:0] keep;
        sh   = {b, 3'b000};
        keep = ~(32'hFFFF_FFFF >> sh);
        return (w >> sh) | (rt & keep);
    endfunction

endpackage

// File: rtl/mau_load_align.sv
// mau_load_align
//   Combinational load formatting: selects the addressed lane(s) of the bus
//   word, sign/zero-extends, or merges with the old register for LWL/LWR.
//   Ports:
//     op       in  ls_op_t  load operation
//     mem_data in  32       word read from the bus
//     rt_data  in  32       old destination register value (LWL/LWR merge)
//     lane_b   in  2        byte offset already adjusted for access size
//     result   out 32       value to write back
module mau_load_align
    import mem_access_pkg::*;
(
    input  ls_op_t      op,
    input  logic [31:0] mem_data,
    input  logic [31:0] rt_data,
    input  logic [1:0]  lane_b,
    output logic [31:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = lane_byte(mem_data, lane_b);
        half_v = lane_half(mem_data, lane_b);
        result = mem_data;
        case (op)
            LB:      result = {{24{byte_v[7]}}, byte_v};
            LBU:     result = {24'h000000, byte_v};
            LH:      result = {{16{half_v[15]}}, half_v};
            LHU:     result = {16'h0000, half_v};
            LWL:     result = merge_lwl(mem_data, rt_data, lane_b);
            LWR:     result = merge_lwr(mem_data, rt_data, lane_b);
            default: result = mem_data;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Fetches one instruction word, then performs the load/store/LUI it is told
//   about on op/rs_data/rt_data/offset, and reports completion with a one-cycle
//   done pulse.  Sequence: IDLE -> FETCH -> DECODE -> (MEM) -> WB -> IDLE.
//   Optional feature: define MAU_ALIGN_EXC_EN to trap misaligned LH/LHU/SH/LW/SW
//   (exc_unaligned in WB, no bus access); otherwise the low address bits are
//   masked for halfword/word accesses and exc_unaligned stays 0.
//   Ports:
//     clk, rst_n               clock (rising edge), async active-low reset
//     start, pc_in             begin instruction at pc_in (ignored while busy)
//     busy, done               not-idle flag, one-cycle completion pulse
//     instr_out                fetched instruction word
//     op, rs_data, rt_data, offset   operation operands sampled in DECODE
//     reg_writeenable/reg_writedata  register write-back (loads, LUI)
//     exc_unaligned, bus_error       completion status flags
//     mem_*, waitrequest             Avalon-MM master
//     dbg_state                      current sequencing state
//   Bus handshake: a transfer is presented by holding mem_read or mem_write
//   with address/byteenable/writedata constant; it completes in the first cycle
//   where waitrequest=0 (read data captured that cycle).  MAX_WAIT consecutive
//   waitrequest cycles abandon the transfer with bus_error.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              busy,
    output logic              done,
    output logic [31:0]       instr_out,
    input  ls_op_t            op,
    input  logic [31:0]       rs_data,
    input  logic [31:0]       rt_data,
    input  logic [15:0]       offset,
    output logic              reg_writeenable,
    output logic [31:0]       reg_writedata,
    output logic              exc_unaligned,
    output logic              bus_error,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              waitrequest,
    output state_t            dbg_state
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_q, ea_q, ea;
    ls_op_t            op_q;
    logic [31:0]       rt_q, rdata_q, load_result;
    logic [15:0]       off_q;
    logic [1:0]        lane_b;
    logic [7:0]        wait_cnt;
    logic              exc_q, misaligned, bus_err_q, in_bus_phase, timeout;
    logic              unused_pc_bits;

    assign ea             = ADDR_W'(rs_data) + {{(ADDR_W-16){offset[15]}}, offset};
    assign in_bus_phase   = (state == S_FETCH) || (state == S_MEM);
    assign timeout        = in_bus_phase && waitrequest && (wait_cnt == WAIT_LAST);
    assign dbg_state      = state;
    assign unused_pc_bits = ^pc_q[1:0];

    always_comb begin
        misaligned = 1'b0;
`ifdef MAU_ALIGN_EXC_EN
        case (op)
            LH, LHU, SH: misaligned = ea[0];
            LW, SW:      misaligned = |ea[1:0];
            default:     misaligned = 1'b0;
        endcase
`endif
    end

    // Halfword and word accesses never straddle a bus word: drop the low bits.
    always_comb begin
        lane_b = ea_q[1:0];
        case (op_q)
            LH, LHU, SH: lane_b = {ea_q[1], 1'b0};
            LW, SW:      lane_b = 2'b00;
            default:     lane_b = ea_q[1:0];
        endcase
    end

    mau_load_align u_load_align (
        .op       (op_q),
        .mem_data (rdata_q),
        .rt_data  (rt_q),
        .lane_b   (lane_b),
        .result   (load_result)
    );

    // State register and datapath captures
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc_q      <= '0;
            instr_out <= '0;
            op_q      <= NOP;
            rt_q      <= '0;
            off_q     <= '0;
            ea_q      <= '0;
            rdata_q   <= '0;
            exc_q     <= 1'b0;
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            bus_err_q <= timeout;
            if (state == S_IDLE && start) pc_q <= pc_in;
            if (state == S_FETCH && !waitrequest) instr_out <= mem_readdata;
            if (state == S_DECODE) begin
                op_q  <= op;
                rt_q  <= rt_data;
                off_q <= offset;
                ea_q  <= ea;
                exc_q <= misaligned;
            end
            if (state == S_MEM && !waitrequest) rdata_q <= mem_readdata;
            if (in_bus_phase && waitrequest && !timeout) wait_cnt <= wait_cnt + 8'd1;
            else                                         wait_cnt <= '0;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH: begin
                if (timeout)          state_nxt = S_IDLE;
                else if (!waitrequest) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (misaligned)                      state_nxt = S_WB;
                else if (is_load(op) || is_store(op)) state_nxt = S_MEM;
                else                                  state_nxt = S_WB;
            end
            S_MEM: begin
                if (timeout)          state_nxt = S_IDLE;
                else if (!waitrequest) state_nxt = S_WB;
            end
            S_WB:     state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs; a timeout reports done/bus_error from IDLE in the following cycle.
    always_comb begin
        busy            = (state != S_IDLE);
        done            = bus_err_q;
        bus_error       = bus_err_q;
        exc_unaligned   = 1'b0;
        reg_writeenable = 1'b0;
        reg_writedata   = '0;
        mem_address     = '0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byteenable  = 4'b0000;
        mem_writedata   = '0;
        case (state)
            S_FETCH: begin
                mem_read       = 1'b1;
                mem_address    = {pc_q[ADDR_W-1:2], 2'b00};
                mem_byteenable = 4'b1111;
            end
            S_MEM: begin
                mem_address = {ea_q[ADDR_W-1:2], 2'b00};
                if (is_store(op_q)) begin
                    mem_write = 1'b1;
                    case (op_q)
                        SB: begin
                            mem_byteenable = 4'b0001 << lane_b;
                            mem_writedata  = {4{rt_q[7:0]}};
                        end
                        SH: begin
                            mem_byteenable = 4'b0011 << lane_b;
                            mem_writedata  = {2{rt_q[15:0]}};
                        end
                        default: begin
                            mem_byteenable = 4'b1111;
                            mem_writedata  = rt_q;
                        end
                    endcase
                end else begin
                    mem_read       = 1'b1;
                    mem_byteenable = 4'b1111;
                end
            end
            S_WB: begin
                done          = 1'b1;
                exc_unaligned = exc_q;
                if (!exc_q && (is_load(op_q) || op_q == LUI)) begin
                    reg_writeenable = 1'b1;
                    reg_writedata   = (op_q == LUI) ? {off_q, 16'h0000} : load_result;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    import mem_access_pkg::*;

    localparam int XW = 70;  // {write, read, address[31:0], byteenable[3:0], writedata[31:0]}
    localparam int RW = 75;  // {we, writedata[31:0], bus_error, exc, cycles[7:0], instr[31:0]}

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        start, busy, done;
    logic [31:0] pc_in, instr_out;
    ls_op_t      op_i;
    logic [31:0] rs_data, rt_data;
    logic [15:0] offset;
    logic        reg_writeenable, exc_unaligned, bus_error;
    logic [31:0] reg_writedata;
    logic [31:0] mem_address, mem_writedata, mem_readdata;
    logic        mem_read, mem_write, waitrequest;
    logic [3:0]  mem_byteenable;
    state_t      dbg_state;

    mem_access_unit #(.ADDR_W(32), .MAX_WAIT(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .pc_in           (pc_in),
        .busy            (busy),
        .done            (done),
        .instr_out       (instr_out),
        .op              (op_i),
        .rs_data         (rs_data),
        .rt_data         (rt_data),
        .offset          (offset),
        .reg_writeenable (reg_writeenable),
        .reg_writedata   (reg_writedata),
        .exc_unaligned   (exc_unaligned),
        .bus_error       (bus_error),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byteenable  (mem_byteenable),
        .mem_writedata   (mem_writedata),
        .mem_readdata    (mem_readdata),
        .waitrequest     (waitrequest),
        .dbg_state       (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [XW-1:0] xfer_q[$];
    logic [RW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_xfer(input logic [1:0] kind, input logic [31:0] addr,
                               input logic [3:0] be, input logic [31:0] wd);
        xfer_q.push_back({kind, addr, be, wd});
    endtask

    task automatic expect_res(input logic we, input logic [31:0] wd, input logic berr,
                              input logic exc, input logic [7:0] cyc, input logic [31:0] instr);
        exp_q.push_back({we, wd, berr, exc, cyc, instr});
    endtask

    // ---------------- driver + bus responder ----------------
    task automatic run(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                       input ls_op_t o, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [15:0] off, input logic [31:0] rdata,
                       input int wf, input int wm, input bit hold_start);
        logic [XW-1:0] cur, e;
        logic [RW-1:0] r;
        int cyc, waits_left, n_xfer;
        bit in_xfer, finished, overlap, early_we;
        start = 1'b1; pc_in = pc; op_i = o; rs_data = rs; rt_data = rt; offset = off;
        waitrequest = 1'b0;
        cyc = 0; n_xfer = 0; waits_left = 0; e = '0;
        in_xfer = 0; finished = 0; overlap = 0; early_we = 0;
        while (!finished && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (hold_start) pc_in = 32'hFFFF_FFF0;
            else            start = 1'b0;
            if (cyc == 1) chk({tag, "_state_fetch"}, dbg_state, S_FETCH);
            if (mem_read && mem_write) overlap = 1;
            cur = {mem_write, mem_read, mem_address, mem_byteenable, mem_writedata};
            if (mem_read || mem_write) begin
                if (!in_xfer) begin
                    in_xfer = 1;
                    waits_left = (n_xfer == 0) ? wf : wm;
                    n_xfer++;
                    if (xfer_q.size() == 0) chk({tag, "_xfer_extra"}, cur, '0);
                    else begin
                        e = xfer_q.pop_front();
                        chk({tag, "_xfer"}, cur, e);
                    end
                end else begin
                    chk({tag, "_xfer_hold"}, cur, e);
                end
                if (waits_left > 0) begin
                    waitrequest  = 1'b1;
                    mem_readdata = 32'hBAD0_BAD0;
                    waits_left--;
                end else begin
                    waitrequest  = 1'b0;
                    mem_readdata = (n_xfer == 1) ? instr : rdata;
                    in_xfer = 0;
                end
            end else begin
                waitrequest = 1'b0;
                in_xfer = 0;
            end
            if (done) begin
                finished = 1;
                start = 1'b0;
                if (exp_q.size() == 0) chk({tag, "_res_extra"}, reg_writedata, '1);
                else begin
                    r = exp_q.pop_front();
                    chk({tag, "_result"}, {reg_writeenable, reg_writedata, bus_error,
                                           exc_unaligned, 8'(cyc), instr_out}, r);
                end
            end else if (reg_writeenable) begin
                early_we = 1;
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, finished, 1'b1);
        chk({tag, "_rd_wr_excl_we"}, {overlap, early_we}, 2'b00);
        @(posedge clk); #1;
        chk({tag, "_after"}, {done, busy, bus_error, reg_writeenable}, 4'b0000);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0; pc_in = '0; op_i = NOP; rs_data = '0; rt_data = '0;
        offset = '0; mem_readdata = '0; waitrequest = 1'b0;
        #1;
        chk("reset_flags", {busy, done, mem_read, mem_write, reg_writeenable, bus_error,
                            exc_unaligned, mem_byteenable}, '0);
        chk("reset_data", {instr_out, mem_address, reg_writedata}, '0);
        chk("reset_state", dbg_state, S_IDLE);
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;

        // LW right after reset release: first edge takes the start
        expect_xfer(2'b01, 32'h14, 4'hF, 0); expect_xfer(2'b01, 32'h0C, 4'hF, 0);
        expect_res(1, 32'h40, 0, 0, 4, 32'h50);
        run("lw", 32'd20, 32'h50, LW, 0, 0, 16'd12, 32'h40, 0, 0, 0);

        expect_xfer(2'b01, 32'h100, 4'hF, 0); expect_xfer(2'b01, 32'h10, 4'hF, 0);
        expect_res(1, 32'hFFFF_F987, 0, 0, 4, 32'h1111);
        run("lh", 32'h100, 32'h1111, LH, 0, 0, 16'd18, 32'hF987_6543, 0, 0, 0);

        expect_xfer(2'b01, 32'h100, 4'hF, 0); expect_xfer(2'b01, 32'h10, 4'hF, 0);
        expect_res(1, 32'h0000_F987, 0, 0, 4, 32'h2222);
        run("lhu", 32'h100, 32'h2222, LHU, 0, 0, 16'd18, 32'hF987_6543, 0, 0, 0);

        expect_xfer(2'b01, 32'h104, 4'hF, 0); expect_xfer(2'b10, 32'hFC, 4'b1000, 32'hABAB_ABAB);
        expect_res(0, 0, 0, 0, 4, 32'h3333);
        run("sb", 32'h104, 32'h3333, SB, 32'h100, 32'hAB, 16'hFFFF, 0, 0, 0, 0);

        expect_xfer(2'b01, 32'h108, 4'hF, 0);
        expect_res(1, 32'h1234_0000, 0, 0, 3, 32'h4444);
        run("lui", 32'h108, 32'h4444, LUI, 0, 0, 16'h1234, 0, 0, 0, 0);

        expect_xfer(2'b01, 32'h10C, 4'hF, 0);
        expect_res(0, 0, 0, 0, 3, 32'h5555);
        run("nop", 32'h10C, 32'h5555, NOP, 0, 0, 16'h0, 0, 0, 0, 0);

        // 3 wait cycles in MEM, start held high (must be ignored while busy)
        expect_xfer(2'b01, 32'h110, 4'hF, 0); expect_xfer(2'b01, 32'h204, 4'hF, 0);
        expect_res(1, 32'hDEAD_BEEF, 0, 0, 7, 32'h6666);
        run("lw_wait3", 32'h110, 32'h6666, LW, 32'h200, 0, 16'd4, 32'hDEAD_BEEF, 0, 3, 1);

        expect_xfer(2'b01, 32'h114, 4'hF, 0); expect_xfer(2'b01, 32'h40, 4'hF, 0);
        expect_res(1, 32'hFFFF_FF83, 0, 0, 6, 32'h7777);
        run("lb_fwait2", 32'h114, 32'h7777, LB, 32'h40, 0, 16'd1, 32'h1122_8344, 2, 0, 0);

        expect_xfer(2'b01, 32'h114, 4'hF, 0); expect_xfer(2'b01, 32'h40, 4'hF, 0);
        expect_res(1, 32'h0000_0083, 0, 0, 4, 32'h7778);
        run("lbu", 32'h114, 32'h7778, LBU, 32'h40, 0, 16'd1, 32'h1122_8344, 0, 0, 0);

        expect_xfer(2'b01, 32'h118, 4'hF, 0); expect_xfer(2'b10, 32'h300, 4'b1100, 32'hCAFE_CAFE);
        expect_res(0, 0, 0, 0, 4, 32'h8888);
        run("sh", 32'h118, 32'h8888, SH, 32'h300, 32'h1234_CAFE, 16'd2, 0, 0, 0, 0);

        expect_xfer(2'b01, 32'h11C, 4'hF, 0); expect_xfer(2'b10, 32'h18, 4'hF, 32'hA5A5_1234);
        expect_res(0, 0, 0, 0, 4, 32'h9999);
        run("sw", 32'h11C, 32'h9999, SW, 32'h10, 32'hA5A5_1234, 16'd8, 0, 0, 0, 0);

        expect_xfer(2'b01, 32'h120, 4'hF, 0); expect_xfer(2'b01, 32'h20, 4'hF, 0);
        expect_res(1, 32'h2211_CCDD, 0, 0, 4, 32'hAAAA);
        run("lwl", 32'h120, 32'hAAAA, LWL, 32'h20, 32'hAABB_CCDD, 16'd1, 32'h4433_2211, 0, 0, 0);

        expect_xfer(2'b01, 32'h124, 4'hF, 0); expect_xfer(2'b01, 32'h20, 4'hF, 0);
        expect_res(1, 32'hAA44_3322, 0, 0, 4, 32'hBBBB);
        run("lwr", 32'h124, 32'hBBBB, LWR, 32'h20, 32'hAABB_CCDD, 16'd1, 32'h4433_2211, 0, 0, 0);

        // waitrequest never drops in MEM: 16 wait cycles then bus_error
        expect_xfer(2'b01, 32'h130, 4'hF, 0); expect_xfer(2'b01, 32'h40, 4'hF, 0);
        expect_res(0, 0, 1, 0, 19, 32'hCCCC);
        run("lw_timeout", 32'h130, 32'hCCCC, LW, 0, 0, 16'h40, 32'h1, 0, 100, 0);

        // LW at effective address 0x13
        expect_xfer(2'b01, 32'h134, 4'hF, 0);
`ifdef MAU_ALIGN_EXC_EN
        expect_res(0, 0, 0, 1, 3, 32'hDDDD);
`else
        expect_xfer(2'b01, 32'h10, 4'hF, 0);
        expect_res(1, 32'h0102_0304, 0, 0, 4, 32'hDDDD);
`endif
        run("lw_unaligned", 32'h134, 32'hDDDD, LW, 32'h10, 0, 16'd3, 32'h0102_0304, 0, 0, 0);

        // Reset asserted while a MEM read is waiting
        start = 1'b1; pc_in = 32'h140; op_i = LW; rs_data = 0; offset = 16'h20;
        waitrequest = 1'b0; mem_readdata = 32'hEEEE;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_pre_mem_read", {mem_read, dbg_state}, {1'b1, S_MEM});
        waitrequest = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); rst_n = 1'b0; #1;
        chk("rst_async_outputs", {mem_read, busy, done, dbg_state}, '0);
        chk("rst_async_instr", instr_out, 32'h0);
        @(negedge clk); rst_n = 1'b1; waitrequest = 1'b0;

        expect_xfer(2'b01, 32'h144, 4'hF, 0); expect_xfer(2'b01, 32'h24, 4'hF, 0);
        expect_res(1, 32'h77, 0, 0, 4, 32'hF0F0);
        run("lw_after_rst", 32'h144, 32'hF0F0, LW, 0, 0, 16'h24, 32'h77, 0, 0, 0);

        chk("scoreboard_drained", {xfer_q.size(), exp_q.size()}, '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: ADDR_W, 32, width of pc_in, rs_data-derived effective address and mem_address.
REQ-002 Parameter: MAX_WAIT, 16, maximum consecutive waitrequest cycles tolerated per bus transfer (1..255).
REQ-003 Ports: clk  in  1  single clock, rising edge; all state updates on this edge.
REQ-004 Ports: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 Ports: start in 1 begin instruction; pc_in in ADDR_W fetch address; busy out 1 unit not IDLE; done out 1 one-cycle completion pulse.
REQ-006 Ports: instr_out out 32 fetched instruction; op in 4 ls_op_t; rs_data, rt_data in 32; offset in 16 signed immediate.
REQ-007 Ports: reg_writeenable out 1; reg_writedata out 32; exc_unaligned out 1; bus_error out 1.
REQ-008 Ports: mem_address out ADDR_W; mem_read out 1; mem_write out 1; mem_byteenable out 4; mem_writedata out 32; mem_readdata in 32; waitrequest in 1 (Avalon-MM, byte lane k = bits 8k+7:8k).

Function
REQ-009 FSM states IDLE, FETCH, DECODE, MEM, WB; IDLE->FETCH when start=1 (pc_in latched); start while busy ignored.
REQ-010 FETCH: mem_read=1, mem_address=latched pc word-aligned, byteenable 4'b1111; hold all bus outputs while waitrequest=1; on waitrequest=0 latch mem_readdata into instr_out, go DECODE.
REQ-011 DECODE (exactly 1 cycle): sample op, rs_data, rt_data, offset; ea = rs_data + sign_extend(offset) mod 2^ADDR_W; b = ea[1:0].
REQ-012 DECODE->MEM for loads/stores; DECODE->WB for LUI and NOP (no bus access).
REQ-013 MEM: mem_address = {ea[ADDR_W-1:2],2'b00}; loads assert mem_read, stores assert mem_write; outputs held stable while waitrequest=1; transfer completes on waitrequest=0, read data latched that cycle; ->WB.
REQ-014 Loads: LW word; LH/LHU half at lanes b,b+1 sign/zero-extended; LB/LBU byte at lane b sign/zero-extended.
REQ-015 LWL: result = (mem << 8*(3-b)) | (rt_data & low 8*(3-b) bits); LWR: result = (mem >> 8*b) | (rt_data & high 8*b bits).
REQ-016 LUI: result = {offset,16'h0000}.
REQ-017 Stores: SW byteenable 4'b1111, data rt_data; SH byteenable 4'b0011<<b, data {2{rt_data[15:0]}}; SB byteenable 4'b0001<<b, data {4{rt_data[7:0]}}.
REQ-018 WB (exactly 1 cycle): done=1; reg_writeenable=1 with reg_writedata for loads/LUI only; ->IDLE.
REQ-019 Latency with zero wait: load 4 cycles start->done, LUI/NOP 3 cycles; each waitrequest cycle adds 1.
REQ-020 Wait counter counts consecutive waitrequest cycles in FETCH/MEM; reaching MAX_WAIT drops mem_read/mem_write, pulses bus_error and done for 1 cycle, no register write, ->IDLE.
REQ-021 mem_read and mem_write never asserted together; both 0 in IDLE, DECODE, WB.

Reset
REQ-022 rst_n=0 at any time, including mid-transfer: state IDLE, all outputs 0, instr_out 0, wait counter 0, immediately and asynchronously.
REQ-023 First start honoured on the first rising edge after rst_n deasserts.

Configuration
REQ-024 Macro MAU_ALIGN_EXC_EN defined: LH/LHU/SH with b[0]=1, LW/SW with b!=0 skip MEM, go WB with exc_unaligned=1 and done=1, no register write, no bus access.
REQ-025 Macro undefined: exc_unaligned tied 0; halfword accesses use b&2'b10, word accesses use b=0.

Structure
REQ-026 Package mem_access_pkg holds ls_op_t (NOP=0, LB, LBU, LH, LHU, LW, LWL, LWR, LUI, SB, SH, SW), state enum, lane-extract/merge functions.
REQ-027 One sub-module mau_load_align: combinational lane extract/extend/LWL-LWR merge; FSM and bus control stay in mem_access_unit.

Verification
REQ-028 LW: pc_in=20, instr 50, rs=0, offset=12, readdata 40 -> fetch addr 20, mem addr 12, reg_writedata 40, done at cycle 4.
REQ-029 LH/LHU: rs=0, offset=18, readdata F9876543 -> addr 16, LH FFFFF987, LHU 0000F987.
REQ-030 SB: rs=0x100, offset=-1 (FFFF), rt=0xAB -> addr 0xFC, byteenable 1000, writedata ABABABAB, no reg write.
REQ-031 waitrequest 3 cycles in MEM -> bus outputs stable, done at cycle 7; waitrequest held 16 cycles -> bus_error and done pulse, reg_writeenable 0.
REQ-032 LW at ea 0x13 -> with MAU_ALIGN_EXC_EN exc_unaligned=1, no mem_read in MEM; without it addr 0x10 loaded normally.
REQ-033 rst_n low during MEM wait -> mem_read 0 same cycle, busy 0; next start completes normally.
